// File: rtl/a_operand_fetch.sv
// a_operand_fetch: streams matrix A row-replayed from BRAM as a valid/ready word stream for C = A x B.
// Define A_FETCH_CHKSUM_EN to add chksum_o, the running sum of accepted words.
module a_operand_fetch #(
  parameter int N    = 2,
  parameter int P    = 4,
  parameter int M    = 3,
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int BASE = 0
) (
  input  logic          clkaA,
  input  logic          reset,
  input  logic          wr_done,
  input  logic          start,
  output logic [AW-1:0] addr_o,
  input  logic [DW-1:0] rdata_i,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [DW-1:0] a_data,
  output logic [7:0]    a_row,
  output logic [7:0]    a_col,
  output logic [7:0]    a_k,
  output logic          a_last_k,
  output logic          a_last,
  output logic          busy,
  output logic          done
`ifdef A_FETCH_CHKSUM_EN
  ,
  output logic [DW-1:0] chksum_o
`endif
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int JW = M > 1 ? $clog2(M) : 1;
  localparam int KW = P > 1 ? $clog2(P) : 1;
  if (((longint'(BASE) + longint'(N * P) - 1) >> AW) != 0) begin : g_addr_chk
    $error("a_operand_fetch: BASE + N*P - 1 does not fit in AW address bits");
  end
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [IW-1:0] row;
    logic [JW-1:0] col;
    logic [KW-1:0] k;
    logic          last_k;
    logic          last;
  } tag_t;
  typedef struct packed {
    logic [DW-1:0] data;
    tag_t          tag;
  } entry_t;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          v1_q, v2_q;
  tag_t          t1_q, t2_q, t_d;
  // Three slots absorb the two-cycle read pipeline so the stream runs at one word per cycle.
  entry_t        fifo_q [3];
  logic [1:0]    wp_q, rp_q, cnt_q;
  entry_t        head;
  logic          accept, issue, fire, k_end, j_end, i_end;
  logic [2:0]    occ;
  assign head    = fifo_q[rp_q];
  assign a_valid = cnt_q != 2'd0;
  assign fire    = a_valid && a_ready;
  assign k_end   = k_q == KW'(P - 1);
  assign j_end   = j_q == JW'(M - 1);
  assign i_end   = i_q == IW'(N - 1);
  assign accept  = (state_q == IDLE || state_q == DONE) && start && wr_done;
  assign occ     = 3'(cnt_q) - 3'(fire) + 3'(v1_q) + 3'(v2_q);
  assign issue   = accept || (state_q == RUN && occ < 3'd3);
  always_comb begin
    state_d = state_q;
    if (issue && k_end && j_end && i_end) state_d = DRAIN;
    else if (accept) state_d = RUN;
    else if (state_q == DRAIN && fire && head.tag.last) state_d = DONE;
    k_d    = issue ? (k_end ? '0 : k_q + 1'b1) : k_q;
    j_d    = issue && k_end ? (j_end ? '0 : j_q + 1'b1) : j_q;
    i_d    = issue && k_end && j_end ? (i_end ? '0 : i_q + 1'b1) : i_q;
    t_d    = '{row: i_q, col: j_q, k: k_q, last_k: k_end, last: k_end && j_end && i_end};
    addr_d = issue ? AW'(BASE + int'(i_q) * P + int'(k_q)) : addr_q;
  end
  always_ff @(posedge clkaA) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      t1_q    <= '0;
      t2_q    <= '0;
      fifo_q  <= '{default: '0};
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      v1_q    <= issue;
      v2_q    <= v1_q;
      if (issue) t1_q <= t_d;
      t2_q    <= t1_q;
      if (v2_q) begin
        fifo_q[wp_q] <= '{data: rdata_i, tag: t2_q};
        wp_q         <= nxt(wp_q);
      end
      if (fire) rp_q <= nxt(rp_q);
      cnt_q   <= cnt_q + 2'(v2_q) - 2'(fire);
    end
  end
  assign addr_o   = addr_q;
  assign a_data   = head.data;
  assign a_row    = 8'(head.tag.row);
  assign a_col    = 8'(head.tag.col);
  assign a_k      = 8'(head.tag.k);
  assign a_last_k = head.tag.last_k;
  assign a_last   = head.tag.last;
  assign busy     = state_q == RUN || state_q == DRAIN;
  assign done     = state_q == DONE;
`ifdef A_FETCH_CHKSUM_EN
  logic [DW-1:0] sum_q;
  always_ff @(posedge clkaA) begin
    if (reset || accept) sum_q <= '0;
    else if (fire) sum_q <= sum_q + a_data;
  end
  assign chksum_o = sum_q;
`endif
endmodule

// File: tb/tb_a_operand_fetch.sv
// tb_a_operand_fetch: directed and randomized-ready stream checks of a_operand_fetch against a loop-order model.
module tb_a_operand_fetch;
  localparam int N = 2, P = 4, M = 3, AW = 8, DW = 32, BASE = 0, TOTAL = N * M * P;
  logic          clkaA = 1'b0, reset = 1'b1, wr_done = 1'b0, start = 1'b0, a_ready = 1'b0;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] rdata_i = '0, a_data;
  logic          a_valid, a_last_k, a_last, busy, done;
  logic [7:0]    a_row, a_col, a_k;
`ifdef A_FETCH_CHKSUM_EN
  logic [DW-1:0] chksum;
`endif
  int            checks = 0, failures = 0, cyc;
  logic [63:0]   exp_w [TOTAL];
  logic [DW-1:0] exp_sum = '0;

  always #5 clkaA = ~clkaA;
  // BRAM model: MEM[a] = a, one-cycle registered read
  always @(posedge clkaA) rdata_i <= DW'(addr_o);

  a_operand_fetch #(.N(N), .P(P), .M(M), .AW(AW), .DW(DW), .BASE(BASE)) dut (
    .clkaA(clkaA), .reset(reset), .wr_done(wr_done), .start(start),
    .addr_o(addr_o), .rdata_i(rdata_i), .a_valid(a_valid), .a_ready(a_ready),
    .a_data(a_data), .a_row(a_row), .a_col(a_col), .a_k(a_k),
    .a_last_k(a_last_k), .a_last(a_last), .busy(busy), .done(done)
`ifdef A_FETCH_CHKSUM_EN
    , .chksum_o(chksum)
`endif
  );

  function automatic logic [63:0] word();
    return {5'b0, a_valid, a_last, a_last_k, a_k, a_col, a_row, a_data};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkaA);
    #1;
  endtask

  // mode 0: ready high; 1: random ready; 2: alternating ready with a 5-cycle stall on word 6
  task automatic collect(input int mode, input bit poke, input int stop, output int cycles);
    int got = 0, n = 0, hold = 0;
    bit held = 1'b0;
    logic [63:0] prev = '0;
    while (got < stop && n < 2000) begin
      if (mode == 0) a_ready = 1'b1;
      else if (mode == 1) a_ready = 1'($urandom_range(0, 1));
      else if (got == 5 && a_valid && hold < 5) begin
        a_ready = 1'b0;
        hold++;
      end else a_ready = 1'(n & 1);
      if (poke) start = ($urandom_range(0, 3) == 0);
      if (held) check("hold_stable", word(), prev);
      if (a_valid && a_ready) begin
        check("word", word(), exp_w[got]);
        got++;
      end
      held = a_valid && !a_ready;
      prev = word();
      tick();
      n++;
    end
    a_ready = 1'b0;
    start   = 1'b0;
    if (n >= 2000) check("stream_timeout", 64'(got), 64'(stop));
    cycles = n;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        for (int k = 0; k < P; k++) begin
          exp_w[(i * M + j) * P + k] = {5'b0, 1'b1, 1'(i == N - 1 && j == M - 1 && k == P - 1),
                                        1'(k == P - 1), 8'(k), 8'(j), 8'(i), 32'(BASE + i * P + k)};
          exp_sum += DW'(BASE + i * P + k);
        end
    repeat (3) tick();
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr", 64'(addr_o), 64'd0);
    reset = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("nowr_busy", 64'(busy), 64'd0);
      check("nowr_valid", 64'(a_valid), 64'd0);
      check("nowr_addr", 64'(addr_o), 64'd0);
    end
    start   = 1'b0;
    wr_done = 1'b1;
    tick();
    kick();
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_addr0", 64'(addr_o), 64'(BASE));
    check("t1_lat0", 64'(a_valid), 64'd0);
    tick();
    check("t1_lat1", 64'(a_valid), 64'd0);
    tick();
    check("t1_lat2", 64'(a_valid), 64'd1);
    collect(0, 1'b0, TOTAL, cyc);
    check("t1_rate", 64'(cyc), 64'(TOTAL));
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_end", 64'(busy), 64'd0);
`ifdef A_FETCH_CHKSUM_EN
    check("chk_sum", 64'(chksum), 64'(exp_sum));
`endif
    kick();
`ifdef A_FETCH_CHKSUM_EN
    check("chk_clear", 64'(chksum), 64'd0);
`endif
    check("t5_restart_busy", 64'(busy), 64'd1);
    check("t5_restart_done", 64'(done), 64'd0);
    collect(1, 1'b1, TOTAL, cyc);
    for (int c = 0; c < 3; c++) begin
      check("t5_no_extra", 64'(a_valid), 64'd0);
      check("t5_done_hold", 64'(done), 64'd1);
      tick();
    end
    kick();
    wr_done = 1'b0;
    collect(2, 1'b0, TOTAL, cyc);
    check("t3_done", 64'(done), 64'd1);
`ifdef A_FETCH_CHKSUM_EN
    check("t3_sum", 64'(chksum), 64'(exp_sum));
`endif
    wr_done = 1'b1;
    kick();
    collect(1, 1'b0, 10, cyc);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_valid", 64'(a_valid), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_done", 64'(done), 64'd0);
    tick();
    kick();
    collect(1, 1'b0, TOTAL, cyc);
    check("t4_done_end", 64'(done), 64'd1);
`ifdef A_FETCH_CHKSUM_EN
    check("t4_sum", 64'(chksum), 64'(exp_sum));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
